// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the two-digit BCD stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } sw_state_t;

  localparam logic [7:0] BCD_ZERO = 8'h00;
  localparam logic [7:0] BCD_MAX  = 8'h99;

endpackage

// File: rtl/BCDcnt.sv
// Two-digit BCD up-counter with async active-low reset and synchronous clear.
module BCDcnt
  import stopwatch_pkg::*;
(
  input  logic       CLK,
  input  logic       CLRN,
  input  logic       CLR_CNT,
  input  logic       INC,
  output logic [7:0] Q
);

  logic [3:0] units, tens;
  logic [7:0] q_next;

  assign units = Q[3:0];
  assign tens  = Q[7:4];

  always_comb begin
    q_next = Q;
    if (Q == BCD_MAX) begin
      q_next = BCD_ZERO;
    end else if (units == 4'd9) begin
      q_next = {tens + 4'd1, 4'd0};
    end else begin
      q_next = {tens, units + 4'd1};
    end
  end

  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      Q <= BCD_ZERO;
    end else if (CLR_CNT) begin
      Q <= BCD_ZERO;
    end else if (INC) begin
      Q <= q_next;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: prescaler, run/pause/done FSM, lap-hold display and target stop
// around a BCDcnt instance.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       STOP,
  input  logic       CLR,
  input  logic       LAP,
  input  logic [7:0] TARGET,
  output logic [7:0] CNT,
  output logic [7:0] DISP,
  output logic       RUNNING,
  output logic       DONE,
  output logic       LAP_HELD
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  if (TICK_DIV < 2 || TICK_DIV > 65535) begin : gen_bad_div
    $error("stopwatch_ctrl: TICK_DIV must be in 2..65535");
  end

  sw_state_t     state_q;
  logic [PW-1:0] pre_q;
  logic          held_q;
  logic [7:0]    lap_q;
  logic          at_target;
  logic          inc;
  logic          clrn;

  assign clrn      = ~RST;
  assign at_target = (TARGET != BCD_ZERO) && (CNT == TARGET);
  // Gate on target so the counter cannot step past it in the cycle DONE is entered.
  assign inc       = (state_q == StRun) && !STOP && !CLR && (pre_q == PRE_LAST) && !at_target;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre_q <= '0;
    end else if (CLR) begin
      pre_q <= '0;
    end else if (state_q == StRun && !STOP) begin
      pre_q <= (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    end
  end

  // STOP outranks START, so a coincident pair never (re)starts the count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      RUNNING <= 1'b0;
      DONE    <= 1'b0;
    end else if (CLR) begin
      state_q <= StIdle;
      RUNNING <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StPause: begin
          if (START && !STOP) begin
            state_q <= StRun;
            RUNNING <= 1'b1;
          end
        end
        StRun: begin
          if (STOP) begin
            state_q <= StPause;
            RUNNING <= 1'b0;
          end else if (at_target) begin
            state_q <= StDone;
            RUNNING <= 1'b0;
            DONE    <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StDone;
        end
        default: begin
          state_q <= StIdle;
          RUNNING <= 1'b0;
          DONE    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      held_q <= 1'b0;
      lap_q  <= BCD_ZERO;
    end else if (CLR) begin
      held_q <= 1'b0;
      lap_q  <= BCD_ZERO;
    end else if (LAP && (state_q == StRun || state_q == StPause)) begin
      held_q <= !held_q;
      if (!held_q) begin
        lap_q <= CNT;
      end
    end
  end

  assign DISP     = held_q ? lap_q : CNT;
  assign LAP_HELD = held_q;

  BCDcnt u_bcdcnt (
    .CLK     (CLK),
    .CLRN    (clrn),
    .CLR_CNT (CLR),
    .INC     (inc),
    .Q       (CNT)
  );

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with TICK_DIV=4.
module tb_stopwatch_ctrl;

  logic       CLK;
  logic       RST;
  logic       START, STOP, CLR, LAP;
  logic [7:0] TARGET;
  logic [7:0] CNT, DISP;
  logic       RUNNING, DONE, LAP_HELD;

  int n_checks;
  int n_fail;

  stopwatch_ctrl #(
    .TICK_DIV (4)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .STOP     (STOP),
    .CLR      (CLR),
    .LAP      (LAP),
    .TARGET   (TARGET),
    .CNT      (CNT),
    .DISP     (DISP),
    .RUNNING  (RUNNING),
    .DONE     (DONE),
    .LAP_HELD (LAP_HELD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pulse(input logic s, input logic p, input logic c, input logic l);
    START = s;
    STOP  = p;
    CLR   = c;
    LAP   = l;
    tick(1);
    START = 1'b0;
    STOP  = 1'b0;
    CLR   = 1'b0;
    LAP   = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST    = 1'b0;
    START  = 1'b0;
    STOP   = 1'b0;
    CLR    = 1'b0;
    LAP    = 1'b0;
    TARGET = 8'h00;
    #2 RST = 1'b1;
    tick(2);
    check_eq("rst_cnt", CNT, 8'h00);
    check_eq("rst_disp", DISP, 8'h00);
    check_eq("rst_running", RUNNING, 1'b0);
    check_eq("rst_done", DONE, 1'b0);
    check_eq("rst_lap_held", LAP_HELD, 1'b0);
    RST = 1'b0;
    tick(20);
    check_eq("idle_cnt", CNT, 8'h00);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("idle_lap_ignored", LAP_HELD, 1'b0);

    // Run timing from a START sampled at E0.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("run_running", RUNNING, 1'b1);
    tick(3);
    check_eq("run_e3_cnt", CNT, 8'h00);
    tick(1);
    check_eq("run_e4_cnt", CNT, 8'h01);
    tick(36);
    check_eq("run_e40_cnt", CNT, 8'h10);

    // Asynchronous reset mid-run, between clock edges.
    #3 RST = 1'b1;
    #1;
    check_eq("async_rst_cnt", CNT, 8'h00);
    check_eq("async_rst_disp", DISP, 8'h00);
    check_eq("async_rst_running", RUNNING, 1'b0);
    check_eq("async_rst_done", DONE, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    tick(20);
    check_eq("post_rst_cnt", CNT, 8'h00);

    // Pause with prescaler at 2, resume two edges from the next increment.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tick(6);
    check_eq("pause_pre_cnt", CNT, 8'h01);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("pause_running", RUNNING, 1'b0);
    tick(20);
    check_eq("pause_frozen_cnt", CNT, 8'h01);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("resume_running", RUNNING, 1'b1);
    check_eq("resume_e0_cnt", CNT, 8'h01);
    tick(1);
    check_eq("resume_e1_cnt", CNT, 8'h01);
    tick(1);
    check_eq("resume_e2_cnt", CNT, 8'h02);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("clr_cnt", CNT, 8'h00);
    check_eq("clr_running", RUNNING, 1'b0);

    // Target stop at 05.
    TARGET = 8'h05;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tick(19);
    check_eq("tgt_e19_cnt", CNT, 8'h04);
    tick(1);
    check_eq("tgt_e20_cnt", CNT, 8'h05);
    check_eq("tgt_e20_done", DONE, 1'b0);
    tick(1);
    check_eq("tgt_done", DONE, 1'b1);
    check_eq("tgt_done_running", RUNNING, 1'b0);
    check_eq("tgt_done_cnt", CNT, 8'h05);
    tick(40);
    check_eq("tgt_hold_cnt", CNT, 8'h05);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tick(8);
    check_eq("tgt_start_ignored_done", DONE, 1'b1);
    check_eq("tgt_start_ignored_cnt", CNT, 8'h05);
    check_eq("tgt_start_ignored_run", RUNNING, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("tgt_clr_cnt", CNT, 8'h00);
    check_eq("tgt_clr_done", DONE, 1'b0);
    TARGET = 8'h00;

    // STOP in the cycle that would increment.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tick(3);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("stop_inc_cnt", CNT, 8'h00);
    check_eq("stop_inc_running", RUNNING, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_eq("stop_inc_resume_cnt", CNT, 8'h01);

    // CLR and START together land in IDLE.
    pulse(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("clr_start_cnt", CNT, 8'h00);
    check_eq("clr_start_running", RUNNING, 1'b0);
    tick(5);
    check_eq("clr_start_idle_cnt", CNT, 8'h00);

    // Lap hold and 99 -> 00 wrap.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tick(168);
    check_eq("lap_pre_cnt", CNT, 8'h42);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("lap_disp", DISP, 8'h42);
    check_eq("lap_held", LAP_HELD, 1'b1);
    tick(40);
    check_eq("lap_cnt_runs", CNT, 8'h52);
    check_eq("lap_disp_frozen", DISP, 8'h42);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("lap_release_held", LAP_HELD, 1'b0);
    check_eq("lap_release_disp", DISP, 8'h52);
    tick(186);
    check_eq("wrap_99", CNT, 8'h99);
    tick(3);
    check_eq("wrap_99_hold", CNT, 8'h99);
    tick(1);
    check_eq("wrap_00", CNT, 8'h00);
    check_eq("wrap_disp", DISP, 8'h00);
    check_eq("wrap_done", DONE, 1'b0);
    tick(4);
    check_eq("wrap_01", CNT, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Two-digit BCD stopwatch controller that sequences a `BCDcnt` counter instance. It contains:
- a prescaler that paces count increments;
- a run/pause/done state machine driven by single-cycle START/STOP/CLR/LAP strobes;
- a lap-hold display register;
- a target comparator that halts counting at a programmed BCD value.

It sits between the user-input debounce/edge-detect logic and the seven-segment display driver.

## Interface
- TICK_DIV, 10, clock cycles per count increment; legal range 2..65535. Elaboration error outside this range.
- CLK  in  1  system clock, all state updates on rising edge
- RST  in  1  asynchronous reset, active-high
- START  in  1  single-cycle strobe: begin/resume counting
- STOP  in  1  single-cycle strobe: pause counting
- CLR  in  1  single-cycle strobe: synchronous clear to IDLE, count 00
- LAP  in  1  single-cycle strobe: toggle display freeze
- TARGET  in  8  BCD stop value {tens,units}; 8'h00 = no target (free run)
- CNT  out  8  live BCD count from BCDcnt
- DISP  out  8  CNT when not held, else latched lap snapshot
- RUNNING  out  1  high in RUN state
- DONE  out  1  high in DONE state
- LAP_HELD  out  1  high while DISP is frozen

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Strobe priority when coincident: CLR > STOP > START.
- CLR, in any state:
  - next state IDLE;
  - BCDcnt CLR_CNT asserted that cycle;
  - prescaler -> 0;
  - lap hold released.
- IDLE: START -> RUN.
- RUN:
  - STOP -> PAUSE;
  - TARGET != 00 and CNT == TARGET -> DONE.
- PAUSE:
  - START -> RUN;
  - prescaler value retained, so partial ticks are not lost.
- DONE:
  - START and STOP ignored;
  - only CLR exits.
- Prescaler:
  - counts 0..TICK_DIV-1, advancing only in RUN with STOP low;
  - wraps to 0 after TICK_DIV-1.
- BCDcnt INC = (state==RUN) & ~STOP & ~CLR & (prescaler==TICK_DIV-1) & ~(TARGET!=00 & CNT==TARGET).
- BCDcnt CLRN = ~RST. BCDcnt CLR_CNT = CLR.
- Count wraps 99 -> 00 (BCDcnt behaviour). With TARGET = 00 there is no DONE; counting continues through the wrap.
- LAP:
  - In RUN or PAUSE, LAP toggles LAP_HELD.
  - On 0->1, DISP latches the current CNT.
  - While held, DISP stays constant and CNT keeps running.
  - In IDLE/DONE, LAP is ignored.
- TARGET is sampled continuously. If TARGET is changed to a value below CNT, counting continues until a wrap reaches it.

## Timing
- Reset values:
  - state IDLE, prescaler 0;
  - CNT 00, DISP 00;
  - RUNNING 0, DONE 0, LAP_HELD 0.
- RST takes effect immediately (asynchronous), including mid-count or mid-DONE.
- START sampled at edge E0:
  - RUNNING=1 after E0;
  - first INC pulse in the cycle before edge E0+TICK_DIV;
  - CNT=01 after E0+TICK_DIV.
- Increments then occur every TICK_DIV edges.
- STOP in the same cycle as a would-be INC: INC suppressed, prescaler held, PAUSE after that edge.
- Resuming from PAUSE with prescaler p: the next increment occurs TICK_DIV-p edges after START.
- DONE rises one edge after CNT becomes TARGET. No extra increment occurs, because INC is gated and TICK_DIV >= 2.
- CLR: CNT=00, DISP=00 and all flags low one edge after the strobe. CLR with START in the same cycle -> IDLE.
- LAP: DISP frozen value equals CNT in the cycle LAP was sampled.
- All outputs are registered or driven directly from registered state. No input-to-output combinational path except DISP mux select from a register.

## Structure
- Package stopwatch_pkg contains:
  - state enum typedef `sw_state_t` (IDLE, RUN, PAUSE, DONE);
  - constant BCD_ZERO = 8'h00;
  - constant BCD_MAX = 8'h99.
- Sub-module: one instance of BCDcnt (existing). The prescaler, FSM and lap register are local to stopwatch_ctrl.
- Prescaler width = $clog2(TICK_DIV).

## Test plan
Benches run with TICK_DIV=4.
- Reset:
  - RST=1 mid-run -> CNT=00, DISP=00, RUNNING=0, DONE=0 immediately;
  - release RST, no strobes for 20 cycles -> CNT stays 00.
- Run timing, TARGET=00:
  - START at edge E0 -> CNT=01 after E0+4;
  - CNT=10 after E0+40.
- Pause/resume:
  - START, STOP after 6 edges -> CNT=01 frozen for 20 cycles;
  - START -> CNT=02 exactly 2 edges later (prescaler retained).
- Target:
  - TARGET=8'h05, START -> DONE=1 one edge after CNT=05;
  - CNT holds 05 for 40 cycles; START ignored;
  - CLR -> CNT=00, DONE=0.
- Wrap and lap:
  - TARGET=00, run to CNT=99 -> next increment CNT=00;
  - LAP at CNT=42 -> DISP holds 42, LAP_HELD=1 while CNT advances;
  - second LAP -> DISP tracks CNT.
- Coincident strobes:
  - CLR+START same cycle -> IDLE, CNT=00;
  - STOP in the INC cycle -> CNT not incremented, state PAUSE.
